// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32I pipeline hazard/sequencing controller:
// result-select encodings, forwarding-select encodings and controller states.
package pipeline_pkg;

  // ResultSrc encodings of the instruction in E
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Operand forwarding selects for the E stage
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  // Controller states: normal run, waiting on data memory, hung-memory trap
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } pctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_fwd_sel.sv
// Forwarding comparator for one E-stage source operand.
// M stage has priority over W stage; register x0 is never forwarded.
module fwd_sel
  import pipeline_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  // Pick the youngest in-flight producer of rs_e, else the register file
  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
      fwd = FWD_M;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// Generates stage stall/flush controls, E-stage forwarding selects, and
// freezes the pipeline while data memory is busy, with a watchdog that
// traps a hung memory in ERROR until reset.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
//
// Handshake: mem_busy is a level. While it is high the M-stage access has
// not completed and every stage holds; the cycle it is low the access
// completes and the pipeline advances (unless the watchdog has tripped).
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             mem_busy,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              WC_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

  pctrl_state_t    state, state_n;
  logic [WC_W-1:0] wait_cnt, wait_cnt_n;
  logic [1:0]      fwd_a, fwd_b;
  logic            lw_hz, frz;

  fwd_sel u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_a)
  );

  fwd_sel u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_b)
  );

  // State and watchdog counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
    end
  end

  // Next state: count consecutive busy cycles, trap once the limit is exceeded
  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    case (state)
      RUN: begin
        if (mem_busy) begin
          state_n    = MEM_WAIT;
          wait_cnt_n = WC_W'(1);
        end else begin
          wait_cnt_n = '0;
        end
      end
      MEM_WAIT: begin
        if (!mem_busy) begin
          state_n    = RUN;
          wait_cnt_n = '0;
        end else if (wait_cnt == WC_MAX) begin
          state_n = ERROR;
        end else begin
          wait_cnt_n = wait_cnt + WC_W'(1);
        end
      end
      ERROR: begin
        state_n = ERROR;
      end
      default: begin
        state_n    = RUN;
        wait_cnt_n = '0;
      end
    endcase
  end

  // Stage controls: freeze dominates; redirect beats load-use; reset forces bubbles
  always_comb begin
    lw_hz       = (ResultSrcE == RES_MEM) && (RdE != 5'd0) &&
                  ((RdE == Rs1D) || (RdE == Rs2D));
    frz         = mem_busy || (state == ERROR);
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushW      = 1'b0;
    ForwardAE   = fwd_a;
    ForwardBE   = fwd_b;
    mem_timeout = (state == ERROR);
    if (!rst_n) begin
      FlushD      = 1'b1;
      FlushE      = 1'b1;
      FlushW      = 1'b1;
      ForwardAE   = FWD_RF;
      ForwardBE   = FWD_RF;
      mem_timeout = 1'b0;
    end else if (frz) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_hz && !PCSrcE;
      StallD = lw_hz && !PCSrcE;
      FlushD = PCSrcE;
      FlushE = PCSrcE || lw_hz;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Count fetch-stall cycles and redirects; both wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (StallF) stall_q <= stall_q + CNT_W'(1);
      if (FlushD) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl (MEM_TIMEOUT=4). Directed scenarios
// plus a randomized run against a behavioural model built from busy-run
// lengths and the stall/flush rules. Honors PIPE_PERF_CNT_EN for counters.
module tb_pipeline_ctrl;

  localparam int TMO = 4;

  logic        clk;
  logic        rst_n;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE, RegWriteM, RegWriteW, mem_busy;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  // observed vector: StallF,D,E,M | FlushD,E,W | FwdA | FwdB | mem_timeout
  logic [11:0] obs;
  assign obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                ForwardAE, ForwardBE, mem_timeout};

  int errors = 0;
  int checks = 0;

  // model state
  int          busy_run;
  bit          err_m;
  logic [31:0] stall_m, flush_m;
  logic [31:0] exp_q[$];

  pipeline_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .mem_busy(mem_busy),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (RegWriteM && RdM == rs) return 2'b10;
    if (RegWriteW && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [11:0] model_outs();
    bit freeze, load_use, stall_fd, fl_d, fl_e;
    if (!rst_n) return 12'b0000_111_00_00_0;
    freeze   = mem_busy || err_m;
    load_use = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
    if (freeze) return {4'b1111, 3'b001, ref_fwd(Rs1E), ref_fwd(Rs2E), err_m};
    stall_fd = load_use && !PCSrcE;
    fl_d     = PCSrcE;
    fl_e     = PCSrcE || load_use;
    return {stall_fd, stall_fd, 2'b00, fl_d, fl_e, 1'b0,
            ref_fwd(Rs1E), ref_fwd(Rs2E), err_m};
  endfunction

  // advance one clock edge and the model with it
  task automatic tick();
    logic [11:0] e;
    e = model_outs();
    @(posedge clk);
    if (!rst_n) begin
      busy_run = 0;
      err_m    = 1'b0;
      stall_m  = '0;
      flush_m  = '0;
    end else begin
      if (mem_busy) begin
        busy_run++;
        if (busy_run > TMO) err_m = 1'b1;
      end else begin
        busy_run = 0;
      end
`ifdef PIPE_PERF_CNT_EN
      if (e[11]) stall_m = stall_m + 1;
      if (e[7])  flush_m = flush_m + 1;
`endif
    end
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 2'b00; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0; mem_busy = 0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr_inputs();
    rst_n = 1'b0;
    Rs1E = 5'd3; RdM = 5'd3; RegWriteM = 1; mem_busy = 1; PCSrcE = 1;
    #1;
    checks++;
    if (obs !== 12'b0000_111_00_00_0) begin
      errors++; $display("FAIL reset_forced: got %b want %b", obs, 12'b0000_111_00_00_0);
    end
    tick();
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    clr_inputs();
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== 12'd0) begin
      errors++; $display("FAIL reset_release: got %b want %b", obs, 12'd0);
    end
    tick();
  endtask

  task automatic test_forwarding();
    clr_inputs();
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
    #1;
    checks++;
    if (ForwardAE !== 2'b10) begin
      errors++; $display("FAIL fwd_m_priority: got %b want 10", ForwardAE);
    end
    tick();
    RegWriteM = 0;
    #1;
    checks++;
    if (ForwardAE !== 2'b01) begin
      errors++; $display("FAIL fwd_w: got %b want 01", ForwardAE);
    end
    tick();
    Rs2E = 0; RdM = 0; RegWriteM = 1; RdW = 0;
    #1;
    checks++;
    if (ForwardBE !== 2'b00) begin
      errors++; $display("FAIL fwd_x0: got %b want 00", ForwardBE);
    end
    tick();
    Rs2E = 9; RdM = 4; RdW = 9; RegWriteW = 1; Rs1E = 4;
    #1;
    checks++;
    if (ForwardAE !== 2'b10 || ForwardBE !== 2'b01) begin
      errors++; $display("FAIL fwd_split: got %b/%b want 10/01", ForwardAE, ForwardBE);
    end
    tick();
  endtask

  task automatic test_load_use();
    clr_inputs();
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; Rs1D = 2;
    #1;
    checks++;
    if (obs !== 12'b1100_010_00_00_0) begin
      errors++; $display("FAIL load_use: got %b want %b", obs, 12'b1100_010_00_00_0);
    end
    tick();
    RdE = 0; Rs2D = 0;
    #1;
    checks++;
    if (obs !== 12'd0) begin
      errors++; $display("FAIL load_use_x0: got %b want %b", obs, 12'd0);
    end
    tick();
  endtask

  task automatic test_branch();
    clr_inputs();
    PCSrcE = 1;
    #1;
    checks++;
    if (obs !== 12'b0000_110_00_00_0) begin
      errors++; $display("FAIL branch: got %b want %b", obs, 12'b0000_110_00_00_0);
    end
    tick();
    ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
    #1;
    checks++;
    if (obs !== 12'b0000_110_00_00_0) begin
      errors++; $display("FAIL branch_over_lw: got %b want %b", obs, 12'b0000_110_00_00_0);
    end
    tick();
  endtask

  task automatic test_deferred_redirect();
    logic [31:0] exp_s, exp_f;
    do_reset();
    PCSrcE = 1; mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs !== 12'b1111_001_00_00_0) begin
        errors++; $display("FAIL defer_frozen%0d: got %b want %b", i, obs, 12'b1111_001_00_00_0);
      end
      tick();
    end
    mem_busy = 0;
    #1;
    checks++;
    if (obs !== 12'b0000_110_00_00_0) begin
      errors++; $display("FAIL defer_apply: got %b want %b", obs, 12'b0000_110_00_00_0);
    end
    tick();
    PCSrcE = 0;
`ifdef PIPE_PERF_CNT_EN
    exp_s = 32'd3; exp_f = 32'd1;
`else
    exp_s = 32'd0; exp_f = 32'd0;
`endif
    exp_q.push_back(exp_s);
    exp_q.push_back(exp_f);
    #1;
    checks++;
    if (stall_cnt !== exp_q[0]) begin
      errors++; $display("FAIL defer_stall_cnt: got %0d want %0d", stall_cnt, exp_q[0]);
    end
    checks++;
    if (flush_cnt !== exp_q[1]) begin
      errors++; $display("FAIL defer_flush_cnt: got %0d want %0d", flush_cnt, exp_q[1]);
    end
    exp_q.delete();
    tick();
  endtask

  task automatic test_watchdog();
    do_reset();
    mem_busy = 1;
    for (int i = 0; i <= TMO; i++) begin
      #1;
      checks++;
      if (obs !== 12'b1111_001_00_00_0) begin
        errors++; $display("FAIL wd_busy%0d: got %b want %b", i, obs, 12'b1111_001_00_00_0);
      end
      tick();
    end
    #1;
    checks++;
    if (mem_timeout !== 1'b1) begin
      errors++; $display("FAIL wd_trip: got %b want 1", mem_timeout);
    end
    mem_busy = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs !== 12'b1111_001_00_00_1) begin
        errors++; $display("FAIL wd_stuck%0d: got %b want %b", i, obs, 12'b1111_001_00_00_1);
      end
      tick();
    end
    rst_n = 0;
    #1;
    checks++;
    if (obs !== 12'b0000_111_00_00_0) begin
      errors++; $display("FAIL wd_reset_forced: got %b want %b", obs, 12'b0000_111_00_00_0);
    end
    tick();
    rst_n = 1;
    #1;
    checks++;
    if (obs !== 12'd0) begin
      errors++; $display("FAIL wd_recover: got %b want %b", obs, 12'd0);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mem_busy = 1;
    tick();
    rst_n = 0;
    #1;
    checks++;
    if (obs !== 12'b0000_111_00_00_0) begin
      errors++; $display("FAIL midwait_forced: got %b want %b", obs, 12'b0000_111_00_00_0);
    end
    tick();
    rst_n = 1; mem_busy = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (obs !== 12'd0) begin
        errors++; $display("FAIL midwait_run%0d: got %b want %b", i, obs, 12'd0);
      end
      tick();
    end
    mem_busy = 1;
    #1;
    checks++;
    if (obs !== 12'b1111_001_00_00_0) begin
      errors++; $display("FAIL pulse_frozen: got %b want %b", obs, 12'b1111_001_00_00_0);
    end
    tick();
    mem_busy = 0;
    #1;
    checks++;
    if (obs !== 12'd0) begin
      errors++; $display("FAIL pulse_release: got %b want %b", obs, 12'd0);
    end
    tick();
  endtask

  task automatic test_random();
    logic [11:0] e;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst_n      = ($urandom_range(0, 39) != 0);
      mem_busy   = ($urandom_range(0, 1) == 0);
      PCSrcE     = ($urandom_range(0, 3) == 0);
      ResultSrcE = 2'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      #1;
      e = model_outs();
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL rand_outs@%0d: got %b want %b", n, obs, e);
      end
      checks++;
      if (stall_cnt !== stall_m || flush_cnt !== flush_m) begin
        errors++; $display("FAIL rand_cnt@%0d: got %0d/%0d want %0d/%0d",
                           n, stall_cnt, flush_cnt, stall_m, flush_m);
      end
      tick();
    end
  endtask

  // sequence
  initial begin
    busy_run = 0; err_m = 0; stall_m = '0; flush_m = '0;
    clr_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_deferred_redirect();
    test_watchdog();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
